// File: rtl/speed_step_controller.sv
// Speed ramp controller: a level accelerate/brake request FSM with a tick prescaler
// that steps SPEED up by one or down by BRAKE_STEP once every STEP_DIV cycles.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | stopped, waiting for an accelerate request
//   ACCEL  | SPEED += 1 per tick, saturating at MAX_SPEED
//   CRUISE | SPEED held
//   BRAKE  | SPEED -= BRAKE_STEP per tick, saturating at 0
module speed_step_controller #(
  parameter int WIDTH      = 8,
  parameter int MAX_SPEED  = 120,
  parameter int STEP_DIV   = 4,
  parameter int BRAKE_STEP = 2
) (
  input  logic             CLK,
  input  logic             CLR_BAR,
  input  logic             ACCEL_REQ,
  input  logic             BRAKE_REQ,
  output logic [WIDTH-1:0] SPEED,
  output logic [1:0]       STATE,
  output logic             AT_LIMIT,
  output logic             STOPPED,
  output logic             REQ_CONFLICT
);

  localparam int              CW        = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0]   TICK_LAST = CW'(STEP_DIV - 1);
  localparam logic [WIDTH-1:0] SPEED_MAX = WIDTH'(MAX_SPEED);
  localparam logic [WIDTH-1:0] SPEED_DEC = WIDTH'(BRAKE_STEP);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCEL  = 2'b01,
    CRUISE = 2'b10,
    BRAKE  = 2'b11
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    tick_cnt;
  logic             tick;
  logic [WIDTH-1:0] speed_nxt;

  assign tick = (tick_cnt == TICK_LAST);

  // Brake wins over everything, including a simultaneous accelerate request.
  always_comb begin
    state_nxt = state;
    if (BRAKE_REQ) begin
      state_nxt = BRAKE;
    end else begin
      case (state)
        IDLE:    state_nxt = ACCEL_REQ ? ACCEL : IDLE;
        ACCEL:   state_nxt = ACCEL_REQ ? ACCEL : ((SPEED != '0) ? CRUISE : IDLE);
        CRUISE:  state_nxt = ACCEL_REQ ? ACCEL : CRUISE;
        BRAKE:   state_nxt = (SPEED == '0) ? IDLE : (ACCEL_REQ ? ACCEL : CRUISE);
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    speed_nxt = SPEED;
    if (tick) begin
      case (state)
        ACCEL:   speed_nxt = (SPEED < SPEED_MAX) ? SPEED + WIDTH'(1) : SPEED;
        BRAKE:   speed_nxt = (SPEED > SPEED_DEC) ? SPEED - SPEED_DEC : '0;
        default: speed_nxt = SPEED;
      endcase
    end
  end

  // The prescaler restarts on every state change so a freshly entered state
  // always waits a full STEP_DIV cycles before its first step.
  always_ff @(posedge CLK or negedge CLR_BAR) begin
    if (!CLR_BAR) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      SPEED        <= '0;
      REQ_CONFLICT <= 1'b0;
    end else begin
      state        <= state_nxt;
      SPEED        <= speed_nxt;
      REQ_CONFLICT <= ACCEL_REQ & BRAKE_REQ;
      if ((state_nxt != state) || tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + CW'(1);
      end
    end
  end

  assign STATE    = state;
  assign AT_LIMIT = (SPEED == SPEED_MAX);
  assign STOPPED  = (SPEED == '0);

endmodule

// File: tb/tb_speed_step_controller.sv
// Directed plus randomized bench for speed_step_controller against a cycle-level
// behavioural model (state age, saturating arithmetic).
module tb_speed_step_controller;

  localparam int WIDTH = 8;
  localparam int MAXS  = 10;
  localparam int DIV   = 4;
  localparam int BSTEP = 2;

  logic             CLK = 1'b0;
  logic             CLR_BAR = 1'b0;
  logic             ACCEL_REQ = 1'b0;
  logic             BRAKE_REQ = 1'b0;
  logic [WIDTH-1:0] SPEED;
  logic [1:0]       STATE;
  logic             AT_LIMIT;
  logic             STOPPED;
  logic             REQ_CONFLICT;

  int n_assert = 0;
  int n_fail   = 0;

  // model: state 0=IDLE 1=ACCEL 2=CRUISE 3=BRAKE, age = cycles spent in the state
  int m_speed;
  int m_state;
  int m_age;
  bit m_conf;

  speed_step_controller #(
    .WIDTH(WIDTH), .MAX_SPEED(MAXS), .STEP_DIV(DIV), .BRAKE_STEP(BSTEP)
  ) dut (
    .CLK(CLK), .CLR_BAR(CLR_BAR), .ACCEL_REQ(ACCEL_REQ), .BRAKE_REQ(BRAKE_REQ),
    .SPEED(SPEED), .STATE(STATE), .AT_LIMIT(AT_LIMIT), .STOPPED(STOPPED),
    .REQ_CONFLICT(REQ_CONFLICT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_speed = 0;
    m_state = 0;
    m_age   = 0;
    m_conf  = 1'b0;
  endtask

  task automatic model_step(bit a, bit b);
    int nxt;
    bit tick;
    tick = ((m_age % DIV) == DIV - 1);
    if (b) nxt = 3;
    else if (m_state == 0) nxt = a ? 1 : 0;
    else if (m_state == 1) nxt = a ? 1 : ((m_speed > 0) ? 2 : 0);
    else if (m_state == 2) nxt = a ? 1 : 2;
    else nxt = (m_speed == 0) ? 0 : (a ? 1 : 2);
    if (tick && m_state == 1) m_speed = (m_speed + 1 > MAXS) ? MAXS : m_speed + 1;
    else if (tick && m_state == 3) m_speed = (m_speed - BSTEP < 0) ? 0 : m_speed - BSTEP;
    m_age   = (nxt == m_state) ? m_age + 1 : 0;
    m_state = nxt;
    m_conf  = a && b;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".speed"},    32'(SPEED),        m_speed);
    chk({tag, ".state"},    32'(STATE),        m_state);
    chk({tag, ".at_limit"}, 32'(AT_LIMIT),     32'(m_speed == MAXS));
    chk({tag, ".stopped"},  32'(STOPPED),      32'(m_speed == 0));
    chk({tag, ".conflict"}, 32'(REQ_CONFLICT), 32'(m_conf));
  endtask

  task automatic cycle(bit a, bit b, string tag);
    ACCEL_REQ = a;
    BRAKE_REQ = b;
    @(posedge CLK);
    model_step(a, b);
    #1;
    check_all(tag);
  endtask

  task automatic run(bit a, bit b, int n, string tag);
    repeat (n) cycle(a, b, tag);
  endtask

  // reset asserted between edges, checked before the next rising edge
  task automatic mid_reset(string tag);
    #2 CLR_BAR = 1'b0;
    #1 model_reset();
    check_all(tag);
    @(negedge CLK);
    CLR_BAR = 1'b1;
  endtask

  initial begin
    int len;
    bit a;
    bit b;
    logic [WIDTH-1:0] held;

    #1 model_reset();
    check_all("reset");
    @(negedge CLK);
    CLR_BAR = 1'b1;
    run(0, 0, 2, "idle");

    run(1, 0, 21, "accel");
    chk("accel_speed5", 32'(SPEED), 5);
    chk("accel_state", 32'(STATE), 1);

    cycle(0, 0, "cruise");
    chk("cruise_state", 32'(STATE), 2);
    run(0, 0, 3, "cruise_hold");
    chk("cruise_speed5", 32'(SPEED), 5);

    cycle(1, 1, "conflict");
    chk("conflict_state", 32'(STATE), 3);
    chk("conflict_pulse", 32'(REQ_CONFLICT), 1);
    cycle(0, 1, "brake");
    chk("conflict_end", 32'(REQ_CONFLICT), 0);
    run(0, 1, 14, "brake");
    chk("brake_speed0", 32'(SPEED), 0);
    chk("brake_stopped", 32'(STOPPED), 1);
    cycle(0, 0, "release");
    chk("release_idle", 32'(STATE), 0);

    run(1, 0, 60, "limit");
    chk("limit_speed", 32'(SPEED), MAXS);
    chk("limit_flag", 32'(AT_LIMIT), 1);

    mid_reset("reset_limit");
    run(1, 0, 29, "accel7");
    chk("accel_speed7", 32'(SPEED), 7);
    mid_reset("reset_at7");
    chk("reset7_speed", 32'(SPEED), 0);
    chk("reset7_state", 32'(STATE), 0);

    run(1, 0, 13, "accel3");
    held = SPEED;
    chk("toggle_start", 32'(held), 3);
    for (int i = 0; i < 5; i++) begin
      run(0, 1, 2, "toggle_b");
      run(1, 0, 2, "toggle_a");
    end
    chk("toggle_hold", 32'(SPEED), 3);

    repeat (60) begin
      a   = 1'($urandom_range(0, 1));
      b   = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 14);
      run(a, b, len, "rand");
      if ($urandom_range(0, 19) == 0) mid_reset("rand_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/speed_step_controller.md
SPEED_STEP_CONTROLLER -- requirements
Module: speed_step_controller

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of the speed register.
REQ-002 Parameter MAX_SPEED, default 120, SHALL set the upper saturation value of SPEED.
REQ-003 Parameter STEP_DIV, default 4, SHALL set the clock cycles per speed step (tick period); legal range is 2 or more.
REQ-004 Parameter BRAKE_STEP, default 2, SHALL set the SPEED decrement applied per brake tick.
REQ-005 CLK  input  1  SHALL be the single system clock; all state updates occur on its rising edge.
REQ-006 CLR_BAR  input  1  SHALL be the reset: one clock domain, asynchronous assertion, active-low.
REQ-007 ACCEL_REQ  input  1  SHALL be the level accelerate request.
REQ-008 BRAKE_REQ  input  1  SHALL be the level brake request.
REQ-009 SPEED  output  WIDTH  SHALL be the registered current speed.
REQ-010 STATE  output  2  SHALL be the registered FSM state: IDLE=00, ACCEL=01, CRUISE=10, BRAKE=11.
REQ-011 AT_LIMIT  output  1  SHALL be high when SPEED equals MAX_SPEED.
REQ-012 STOPPED  output  1  SHALL be high when SPEED equals 0.
REQ-013 REQ_CONFLICT  output  1  SHALL be a one-cycle registered pulse that marks a cycle in which ACCEL_REQ and BRAKE_REQ were both high.

Function
REQ-014 The tick counter SHALL count 0 to STEP_DIV-1 and wrap; a tick SHALL occur in the cycle where the count equals STEP_DIV-1.
REQ-015 The tick counter SHALL clear to 0 on every STATE change, so the first step occurs STEP_DIV cycles after a state is entered.
REQ-016 BRAKE_REQ=1 SHALL force the next state to BRAKE from any state (brake priority).
REQ-017 In IDLE with ACCEL_REQ=1 and BRAKE_REQ=0, the next state SHALL be ACCEL.
REQ-018 In ACCEL, each tick SHALL increment SPEED by 1, saturating at MAX_SPEED with no wrap.
REQ-019 In ACCEL with ACCEL_REQ=0, the next state SHALL be CRUISE if SPEED>0, otherwise IDLE.
REQ-020 In CRUISE, SPEED SHALL hold; ACCEL_REQ=1 SHALL move the FSM to ACCEL.
REQ-021 In BRAKE, each tick SHALL decrement SPEED by BRAKE_STEP, saturating at 0 (no underflow).
REQ-022 In BRAKE with BRAKE_REQ=0, the next state SHALL be IDLE if SPEED=0, else ACCEL if ACCEL_REQ=1, else CRUISE.
REQ-023 SPEED SHALL change only on a tick in ACCEL or BRAKE, one cycle after the tick (registered).
REQ-024 AT_LIMIT and STOPPED SHALL be decoded combinationally from the registered SPEED.
REQ-025 When ACCEL_REQ and BRAKE_REQ are both high, the FSM SHALL take BRAKE and REQ_CONFLICT SHALL pulse high on the next cycle, once per cycle of overlap.
REQ-026 Arithmetic SHALL be unsigned in WIDTH bits; MAX_SPEED SHALL be at most 2^WIDTH-1.

Reset
REQ-027 CLR_BAR=0 SHALL immediately force SPEED=0, STATE=IDLE, tick counter=0, REQ_CONFLICT=0, STOPPED=1 and AT_LIMIT=0, independent of CLK.
REQ-028 A reset asserted mid-operation SHALL abandon the current step; after CLR_BAR rises, operation SHALL resume from IDLE on the next rising CLK edge.

Verification (STEP_DIV=4, MAX_SPEED=10, BRAKE_STEP=2)
REQ-029 Reset, then ACCEL_REQ held high for 21 cycles -> STATE=01 and SPEED steps 1,2,3,4,5, one step every 4 cycles.
REQ-030 ACCEL_REQ held high for 60 cycles -> SPEED stops at 10, AT_LIMIT=1, no wrap to 0.
REQ-031 Release ACCEL at SPEED=5 -> STATE=10 and SPEED holds at 5; then BRAKE_REQ held -> SPEED steps 3,1,0 and stays 0, STOPPED=1; release brake -> STATE=00.
REQ-032 ACCEL_REQ=1 and BRAKE_REQ=1 together for 1 cycle from CRUISE at SPEED=5 -> STATE=11 and REQ_CONFLICT high for exactly 1 cycle.
REQ-033 CLR_BAR driven low between clock edges during ACCEL at SPEED=7 -> SPEED=0 and STATE=00 before the next CLK edge.
REQ-034 BRAKE_REQ and ACCEL_REQ toggling every 2 cycles (less than STEP_DIV) -> SPEED never changes, because the tick counter clears on every state change.
